// File: rtl/reg_wr_collector_pkg.sv
// Shared definitions for the 40-word register-file write collector.
//   NUM_WORDS : number of implemented words (addresses 0..39)
//   ADDR_W    : address width of every write channel/port
//   NUM_CH    : number of producer channels / file write ports
//   CNT_W     : width of the saturating conflict-stall counter
//   wr_req_t  : {addr, data} write request at the register file's native width
package reg_wr_collector_pkg;

  localparam int unsigned NUM_WORDS = 40;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DATA_W    = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NUM_WORDS);
  endfunction

endpackage

// File: rtl/reg_40xx_wr_collector_fifo.sv
// Per-channel request FIFO (module wr_collector_fifo).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push/push_data : write one entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   head         : current head entry, valid while !empty
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module wr_collector_fifo
  import reg_wr_collector_pkg::*;
#(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign empty   = (occ_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/reg_40xx_wr_collector.sv
// Write-side front end for the 40-word, 2-read/3-write register file.
// Three producers push {addr, data} over valid/ready into per-channel FIFOs;
// an issue stage drives write port N from channel N through registered outputs,
// guaranteeing no same-word multi-port write and no address above 39.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   chN_valid/ready/addr/data : producer channel N (N = 0..2)
//   wrN_en/addr/data          : register-file write port N (registered)
//   clr_err / err_oor         : sticky out-of-range drop flag and its clear
//   conflict_cnt              : saturating count of conflict stalls
//   idle                      : all FIFOs empty and no write issuing
// Optional feature macro: REG_WR_COLLECTOR_BYPASS_EN -- an accepted input that
// finds its FIFO empty competes for issue directly (1-cycle latency).
module reg_40xx_wr_collector
  import reg_wr_collector_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch0_valid,
  output logic              ch0_ready,
  input  logic [ADDR_W-1:0] ch0_addr,
  input  logic [WIDTH-1:0]  ch0_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  input  logic [ADDR_W-1:0] ch1_addr,
  input  logic [WIDTH-1:0]  ch1_data,
  input  logic              ch2_valid,
  output logic              ch2_ready,
  input  logic [ADDR_W-1:0] ch2_addr,
  input  logic [WIDTH-1:0]  ch2_data,
  output logic              wr0_en,
  output logic [ADDR_W-1:0] wr0_addr,
  output logic [WIDTH-1:0]  wr0_data,
  output logic              wr1_en,
  output logic [ADDR_W-1:0] wr1_addr,
  output logic [WIDTH-1:0]  wr1_data,
  output logic              wr2_en,
  output logic [ADDR_W-1:0] wr2_addr,
  output logic [WIDTH-1:0]  wr2_data,
  input  logic              clr_err,
  output logic              err_oor,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              idle
);

  localparam int unsigned REQ_W = ADDR_W + WIDTH;

  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_ready;
  logic [REQ_W-1:0]  in_req    [NUM_CH];
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_push;
  logic [NUM_CH-1:0] fifo_pop;
  logic [REQ_W-1:0]  fifo_head [NUM_CH];

  logic [NUM_CH-1:0] cand_valid;
  logic [NUM_CH-1:0] cand_bypass;
  logic [NUM_CH-1:0] cand_live;
  logic [NUM_CH-1:0] cand_oor;
  logic [NUM_CH-1:0] cand_stall;
  logic [NUM_CH-1:0] cand_issue;
  logic [REQ_W-1:0]  cand_req  [NUM_CH];
  logic [ADDR_W-1:0] cand_addr [NUM_CH];
  logic [WIDTH-1:0]  cand_data [NUM_CH];

  logic [NUM_CH-1:0] en_q;
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [WIDTH-1:0]  data_q [NUM_CH];
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        stall_num;
  logic [CNT_W:0]    cnt_sum;

  assign in_valid  = {ch2_valid, ch1_valid, ch0_valid};
  assign in_req[0] = {ch0_addr, ch0_data};
  assign in_req[1] = {ch1_addr, ch1_data};
  assign in_req[2] = {ch2_addr, ch2_data};

  // Ready follows occupancy only and is held low throughout reset.
  assign in_ready  = ~fifo_full & {NUM_CH{~rst}};
  assign ch0_ready = in_ready[0];
  assign ch1_ready = in_ready[1];
  assign ch2_ready = in_ready[2];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    wr_collector_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[g]),
      .push_data (in_req[g]),
      .pop       (fifo_pop[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // Candidate selection: FIFO head, or (bypass build) the accepted input when
  // the FIFO is empty.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      cand_bypass[n] = 1'b0;
      cand_valid[n]  = ~fifo_empty[n];
      cand_req[n]    = fifo_head[n];
`ifdef REG_WR_COLLECTOR_BYPASS_EN
      if (fifo_empty[n]) begin
        cand_bypass[n] = in_valid[n] & in_ready[n];
        cand_valid[n]  = in_valid[n] & in_ready[n];
        cand_req[n]    = in_req[n];
      end
`endif
      cand_addr[n] = cand_req[n][REQ_W-1 -: ADDR_W];
      cand_data[n] = cand_req[n][WIDTH-1:0];
      cand_live[n] = cand_valid[n] & addr_in_range(cand_addr[n]);
      cand_oor[n]  = cand_valid[n] & ~addr_in_range(cand_addr[n]);
    end
  end

  // A live candidate yields to any lower-index live candidate on the same word,
  // so same-word writes land in channel order and the highest index survives.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      cand_stall[n] = 1'b0;
      for (int m = 0; m < n; m++) begin
        if (cand_live[n] && cand_live[m] && (cand_addr[n] == cand_addr[m])) begin
          cand_stall[n] = 1'b1;
        end
      end
    end
  end

  assign cand_issue = cand_live & ~cand_stall;

  // A consumed bypass candidate never enters its FIFO; a stalled one is queued.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      fifo_pop[n]  = ~cand_bypass[n] & ~fifo_empty[n] & (cand_issue[n] | cand_oor[n]);
      fifo_push[n] = in_valid[n] & in_ready[n] &
                     ~(cand_bypass[n] & (cand_issue[n] | cand_oor[n]));
    end
  end

  always_comb begin
    stall_num = {1'b0, cand_stall[0]} + {1'b0, cand_stall[1]} + {1'b0, cand_stall[2]};
    cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(stall_num);
    cnt_d     = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    // A new drop takes priority over a simultaneous clear.
    err_d = err_q;
    if (clr_err)    err_d = 1'b0;
    if (|cand_oor)  err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        addr_q[n] <= '0;
        data_q[n] <= '0;
      end
    end else begin
      en_q  <= cand_issue;
      err_q <= err_d;
      cnt_q <= cnt_d;
      for (int n = 0; n < NUM_CH; n++) begin
        if (cand_issue[n]) begin
          addr_q[n] <= cand_addr[n];
          data_q[n] <= cand_data[n];
        end
      end
    end
  end

  assign wr0_en       = en_q[0];
  assign wr0_addr     = addr_q[0];
  assign wr0_data     = data_q[0];
  assign wr1_en       = en_q[1];
  assign wr1_addr     = addr_q[1];
  assign wr1_data     = data_q[1];
  assign wr2_en       = en_q[2];
  assign wr2_addr     = addr_q[2];
  assign wr2_data     = data_q[2];
  assign err_oor      = err_q;
  assign conflict_cnt = cnt_q;
  assign idle         = (&fifo_empty) & ~(|en_q);

endmodule

// File: tb/tb_reg_40xx_wr_collector.sv
// Directed, scoreboard-checked bench for reg_40xx_wr_collector.
module tb_reg_40xx_wr_collector;
  import reg_wr_collector_pkg::*;

`ifdef REG_WR_COLLECTOR_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ch0_valid, ch1_valid, ch2_valid;
  logic        ch0_ready, ch1_ready, ch2_ready;
  logic [5:0]  ch0_addr, ch1_addr, ch2_addr;
  logic [63:0] ch0_data, ch1_data, ch2_data;
  logic        wr0_en, wr1_en, wr2_en;
  logic [5:0]  wr0_addr, wr1_addr, wr2_addr;
  logic [63:0] wr0_data, wr1_data, wr2_data;
  logic        clr_err;
  logic        err_oor;
  logic [15:0] conflict_cnt;
  logic        idle;

  logic [2:0]  wr_en;
  logic [5:0]  wr_addr [3];
  logic [63:0] wr_data [3];
  assign wr_en      = {wr2_en, wr1_en, wr0_en};
  assign wr_addr[0] = wr0_addr;
  assign wr_addr[1] = wr1_addr;
  assign wr_addr[2] = wr2_addr;
  assign wr_data[0] = wr0_data;
  assign wr_data[1] = wr1_data;
  assign wr_data[2] = wr2_data;

  int checks = 0;
  int errors = 0;
  wr_req_t q0[$];
  wr_req_t q1[$];
  wr_req_t q2[$];
  logic [63:0] mem [40];

  always #5 clk = ~clk;

  reg_40xx_wr_collector #(.WIDTH(64), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch0_valid    (ch0_valid),
    .ch0_ready    (ch0_ready),
    .ch0_addr     (ch0_addr),
    .ch0_data     (ch0_data),
    .ch1_valid    (ch1_valid),
    .ch1_ready    (ch1_ready),
    .ch1_addr     (ch1_addr),
    .ch1_data     (ch1_data),
    .ch2_valid    (ch2_valid),
    .ch2_ready    (ch2_ready),
    .ch2_addr     (ch2_addr),
    .ch2_data     (ch2_data),
    .wr0_en       (wr0_en),
    .wr0_addr     (wr0_addr),
    .wr0_data     (wr0_data),
    .wr1_en       (wr1_en),
    .wr1_addr     (wr1_addr),
    .wr1_data     (wr1_data),
    .wr2_en       (wr2_en),
    .wr2_addr     (wr2_addr),
    .wr2_data     (wr2_data),
    .clr_err      (clr_err),
    .err_oor      (err_oor),
    .conflict_cnt (conflict_cnt),
    .idle         (idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sb_size(input int n);
    case (n)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_push(input int n, input logic [5:0] a, input logic [63:0] d);
    wr_req_t e;
    e.addr = a;
    e.data = d;
    case (n)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic wr_req_t sb_pop(input int n);
    wr_req_t e;
    case (n)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  task automatic set_ch(input int n, input logic v, input logic [5:0] a, input logic [63:0] d);
    case (n)
      0: begin ch0_valid = v; ch0_addr = a; ch0_data = d; end
      1: begin ch1_valid = v; ch1_addr = a; ch1_data = d; end
      default: begin ch2_valid = v; ch2_addr = a; ch2_data = d; end
    endcase
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 3; n++) set_ch(n, 1'b0, 6'd0, 64'd0);
  endtask

  // Advance one clock, then check every issued write against the scoreboard.
  task automatic tick();
    wr_req_t e;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      if (wr_en[n]) begin
        chk($sformatf("wr%0d_expected_write", n), 64'(sb_size(n) != 0), 64'd1);
        chk($sformatf("wr%0d_in_range", n), 64'(wr_addr[n] < 6'd40), 64'd1);
        if (sb_size(n) != 0) begin
          e = sb_pop(n);
          chk($sformatf("wr%0d_addr", n), 64'(wr_addr[n]), 64'(e.addr));
          chk($sformatf("wr%0d_data", n), wr_data[n], e.data);
        end
        if (wr_addr[n] < 6'd40) mem[wr_addr[n]] = wr_data[n];
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 3; j++) begin
        if (wr_en[i] && wr_en[j]) begin
          chk($sformatf("port_clash_%0d_%0d", i, j), 64'(wr_addr[i] != wr_addr[j]), 64'd1);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit drained;
    bit acc1, acc2;
    logic [2:0] exp_en;
    for (int i = 0; i < 40; i++) mem[i] = '0;
    rst = 1'b1;
    clr_err = 1'b0;
    idle_inputs();

    // Reset state
    #12;
    chk("ready_during_rst", 64'({ch2_ready, ch1_ready, ch0_ready}), 64'd0);
    chk("en_during_rst", 64'(wr_en), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'({ch2_ready, ch1_ready, ch0_ready}), 64'h7);
    chk("en_after_rst", 64'(wr_en), 64'd0);
    chk("idle_after_rst", 64'(idle), 64'd1);
    chk("err_after_rst", 64'(err_oor), 64'd0);
    chk("cnt_after_rst", 64'(conflict_cnt), 64'd0);

    // Single write on ch1
    set_ch(1, 1'b1, 6'd5, 64'hA5);
    sb_push(1, 6'd5, 64'hA5);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("single_en_c%0d", c), 64'(wr_en), (c == LAT - 1) ? 64'h2 : 64'h0);
      tick();
    end
    chk("single_addr_hold", 64'(wr1_addr), 64'd5);
    chk("single_data_hold", wr1_data, 64'hA5);
    chk("single_idle", 64'(idle), 64'd1);

    // Three-way clash on word 12
    for (int n = 0; n < 3; n++) begin
      set_ch(n, 1'b1, 6'd12, 64'(n + 1));
      sb_push(n, 6'd12, 64'(n + 1));
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      exp_en = 3'b000;
      if (c == LAT - 1) exp_en = 3'b001;
      if (c == LAT)     exp_en = 3'b010;
      if (c == LAT + 1) exp_en = 3'b100;
      chk($sformatf("clash_en_c%0d", c), 64'(wr_en), 64'(exp_en));
      tick();
    end
    chk("clash_cnt", 64'(conflict_cnt), 64'd3);
    chk("clash_word12", mem[12], 64'd3);

    // Out-of-range drop on ch2 (any wr2_en here is flagged by the scoreboard)
    set_ch(2, 1'b1, 6'd45, 64'hDEAD);
    tick();
    idle_inputs();
    if (LAT == 2) tick();
    chk("oor_err_set", 64'(err_oor), 64'd1);
    chk("oor_cnt_unchanged", 64'(conflict_cnt), 64'd3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("oor_err_cleared", 64'(err_oor), 64'd0);
    // clr_err coincides with the pop of addr 63: set must win
    set_ch(2, 1'b1, 6'd63, 64'hBEEF);
    clr_err = (LAT == 1);
    tick();
    idle_inputs();
    if (LAT == 2) begin
      clr_err = 1'b1;
      tick();
    end
    clr_err = 1'b0;
    chk("oor_set_beats_clr", 64'(err_oor), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("oor_err_cleared2", 64'(err_oor), 64'd0);

    // Backpressure: ch0 keeps hitting word 7, blocking ch1 on the same word
    k = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_ch0_ready_%0d", i), 64'(ch0_ready), 64'd1);
      set_ch(0, 1'b1, 6'd7, 64'(100 + i));
      sb_push(0, 6'd7, 64'(100 + i));
      set_ch(1, 1'b1, 6'd7, 64'(200 + k));
      acc1 = ch1_ready;
      if (acc1) sb_push(1, 6'd7, 64'(200 + k));
      tick();
      if (acc1) k++;
    end
    chk("bp_ch1_accepted", 64'(k), 64'd2);
    chk("bp_ch1_ready_low", 64'(ch1_ready), 64'd0);
    idle_inputs();
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      tick();
      drained = idle && (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0);
    end
    chk("bp_drained", 64'(drained), 64'd1);
    chk("bp_word7", mem[7], 64'd201);

    // Reset mid-stream with ch1/ch2 FIFOs full
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 6'd20, 64'(300 + i));
      sb_push(0, 6'd20, 64'(300 + i));
      acc1 = ch1_ready;
      acc2 = ch2_ready;
      set_ch(1, 1'b1, 6'd20, 64'(400 + i));
      set_ch(2, 1'b1, 6'd20, 64'(500 + i));
      if (acc1) sb_push(1, 6'd20, 64'(400 + i));
      if (acc2) sb_push(2, 6'd20, 64'(500 + i));
      tick();
    end
    chk("mid_ch1_full", 64'(ch1_ready), 64'd0);
    chk("mid_ch2_full", 64'(ch2_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 64'(wr_en), 64'd0);
    chk("mid_rst_addr", 64'({wr2_addr, wr1_addr, wr0_addr}), 64'd0);
    chk("mid_rst_data", wr0_data | wr1_data | wr2_data, 64'd0);
    chk("mid_rst_ready", 64'({ch2_ready, ch1_ready, ch0_ready}), 64'd0);
    chk("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    idle_inputs();
    q0.delete();
    q1.delete();
    q2.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_idle_%0d", i), 64'(idle), 64'd1);
    end
    chk("post_rst_ready", 64'({ch2_ready, ch1_ready, ch0_ready}), 64'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_40xx_wr_collector.md
Name: reg_40xX_wr_collector

Overview:
- Write-side front end for the 40-word, 2-read/3-write register file.
- Takes writes from three independent producers over valid/ready channels and buffers each channel in a small FIFO.
- Drives the file's three write ports from registered outputs, with two guarantees: no two ports ever target the same word in one cycle, and addresses 40-63 never reach the file.
- Without this block, a same-address multi-port write or an out-of-range address gives an undefined stored value.

Parameters:
- WIDTH, 64, data width per word; must match the register file.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- chN_valid  in  1  (N=0,1,2) producer N has a write
- chN_ready  out  1  channel N FIFO can accept
- chN_addr  in  6  target word
- chN_data  in  WIDTH  write data
- wrN_en  out  1  (N=0,1,2) to register file write port N
- wrN_addr  out  6  to register file write port N
- wrN_data  out  WIDTH  to register file write port N
- clr_err  in  1  synchronous clear of err_oor
- err_oor  out  1  sticky: an out-of-range address was dropped
- conflict_cnt  out  16  saturating count of conflict stalls
- idle  out  1  all FIFOs empty and no write issuing

Behaviour:
- Reset (asynchronous, rst=1):
  - FIFOs empty; all wrN_en/addr/data = 0.
  - err_oor = 0; conflict_cnt = 0.
  - chN_ready = 0 while rst is high, 1 in the first cycle after release.
  - Reset mid-operation discards every queued entry; no partial write is issued.
- Accept:
  - An entry is pushed when chN_valid & chN_ready at the clock edge.
  - chN_ready = !full. It depends on FIFO occupancy only; a pop in the same cycle does not raise ready.
- Port mapping:
  - Channel N always drives write port N.
  - Order within a channel is strictly preserved.
- Issue stage (every cycle), per channel whose FIFO is non-empty:
  - The head is the candidate.
  - If head addr > 39: pop, issue no write, set err_oor. This is not a conflict.
  - Conflict rule: a valid in-range candidate stalls if any lower-index channel has a valid in-range candidate with an equal addr.
  - Non-stalled candidates pop and load their output registers.
  - wrN_en = 1 for exactly one cycle per issued entry; otherwise 0, with wrN_addr/wrN_data holding their last value.
- Same-address ordering:
  - Lower index writes first, so the higher-index value survives.
  - Three-way clash on one word: ch0 issues in cycle t, ch1 in t+1, ch2 in t+2.
- Latency: accept edge to wrN_en high = 2 cycles (FIFO write, then output register load).
- conflict_cnt:
  - Adds the number of channels stalled this cycle (0-2).
  - Saturates at 16'hFFFF with no wrap.
- err_oor:
  - Set on any out-of-range pop.
  - clr_err clears it; a set in the same cycle wins over clr_err.
- idle = all FIFOs empty & no wrN_en asserted; combinational from state.
- Full/empty edges:
  - Pushing into a full FIFO cannot occur (ready = 0).
  - Pop from empty cannot occur (no candidate).
  - Pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.

Optional Feature:
- Macro REG_WR_COLLECTOR_BYPASS_EN.
- Defined: when channel N's FIFO is empty and its accepted input would win issue, it loads the output register directly in the accept cycle and bypasses the FIFO.
  - Latency becomes 1 cycle.
  - The same conflict and out-of-range rules apply to bypass candidates, compared against all other channels' candidates.
- Undefined: every entry passes through the FIFO; latency is fixed at 2.

Decomposition:
- Shared package, reg_wr_collector_pkg:
  - NUM_WORDS = 40, ADDR_W = 6, NUM_CH = 3.
  - CNT_W = 16.
  - A write-request struct {addr, data}.
- One sub-module, wr_collector_fifo: parameterised WIDTH+6 by DEPTH FIFO with push/pop/full/empty.
  - Instantiated three times.

Test Plan:
- Reset release: after rst falls, chN_ready=1, wrN_en=0, idle=1, err_oor=0, conflict_cnt=0.
- Single write ch1 addr 5, data 64'hA5: two cycles later, for one cycle, wr1_en=1, wr1_addr=5, wr1_data=A5; other ports idle. With BYPASS_EN the same write appears one cycle after accept.
- All three channels write addr 12 in the same cycle, data 1/2/3:
  - wr0 issues in cycle t, wr1 in t+1, wr2 in t+2.
  - conflict_cnt ends at 3 (2 + 1).
  - Final word 12 = 3.
- ch2 writes addr 45:
  - No wr2_en; err_oor=1 the next cycle.
  - clr_err pulse returns it to 0.
  - clr_err in the same cycle as a new addr 63 pop leaves err_oor=1.
- Backpressure:
  - Hold ch0 head in conflict with lower index absent... use ch1 blocked by repeated ch0 same-addr writes.
  - ch1_ready drops after DEPTH=2 pushes.
  - All ch1 entries later issue in order.
- Assert rst mid-stream with FIFOs full: outputs clear immediately and queued entries never issue.
